booth_ppm_accum: RTL
====================

// Module: booth_ppm_accum
// PURPOSE
//  Downstream stage of the Booth-2 partial-product generator.
//  - Accepts one complete partial-product matrix (PPM) per transaction.
//  - Reduces it over several cycles into carry-save sum/carry registers using 3:2 compressors.
//  - Resolves the result with one carry-propagate add and returns the unsigned product c.
//  - Provides the multi-cycle, area-lean PPM addition for the Booth multiplier datapath.
// PARAMETERS
//  IN_DATA_WIDTH   32  multiplicand/multiplier width (even)
//  OUT_DATA_WIDTH  64  product width; result taken mod 2^OUT_DATA_WIDTH
//  ROWS_PER_CYCLE  2   PPM rows compressed per ACCUM cycle; legal range 1..BOOTH_NUM
// PORTS
//  clk        in   1                           clock, rising edge
//  rst        in   1                           asynchronous, active-high reset
//  in_valid   in   1                           ppm_flat holds a valid matrix
//  in_ready   out  1                           block can accept a matrix
//  ppm_flat   in   BOOTH_NUM*PPM_ROW_W         row i at bits [i*PPM_ROW_W +: PPM_ROW_W]
//  out_valid  out  1                           c is valid
//  out_ready  in   1                           consumer takes c
//  c          out  OUT_DATA_WIDTH              product
//  busy       out  1                           state != IDLE
// BEHAVIOUR
//  - Derived constants:
//    - BOOTH_NUM = IN_DATA_WIDTH/2+1
//    - PPM_ROW_W = IN_DATA_WIDTH+4
//    - N_ACC = ceil(BOOTH_NUM/ROWS_PER_CYCLE)
//  - Arithmetic:
//    - c = sum over i of (zero-ext row i << 2*i), truncated to OUT_DATA_WIDTH.
//    - Rows already carry the sign-extension prefix bits; add no extra correction.
//  - Reset: state=IDLE; sum, carry, row counter and c all 0; out_valid=0.
//    - Resulting outputs: in_ready=1, busy=0.
//  - FSM IDLE -> ACCUM -> RESOLVE -> DONE -> IDLE:
//    - IDLE: in_ready=1. On in_valid&in_ready, capture ppm_flat, clear sum/carry and row_idx, go ACCUM.
//    - ACCUM: fold rows row_idx..row_idx+R-1 into sum/carry through a chain of R 3:2 layers.
//      - Carry is shifted left 1 per layer and truncated.
//      - row_idx += R; after N_ACC cycles, go RESOLVE.
//      - Row indices >= BOOTH_NUM contribute zero.
//    - RESOLVE: c <= sum+carry; out_valid <= 1; go DONE.
//    - DONE: hold c and out_valid stable until out_valid&out_ready, then out_valid <= 0 and go IDLE.
//  - Latency: out_valid rises N_ACC+1 edges after the accept edge.
//    - Default: 9+1 = 10 edges.
//    - ROWS_PER_CYCLE=BOOTH_NUM: 2 edges.
//  - Throughput: one transaction in flight.
//    - in_ready=0 in every state except IDLE; in_valid while busy is ignored.
//    - in_ready rises the cycle after the DONE handshake; no combinational ready bypass.
//  - Back-pressure: out_ready low holds DONE indefinitely; c is unchanged.
//  - Reset mid-operation: abort immediately, state IDLE, all registers 0; no stale out_valid afterwards.
//  - in_ready depends only on state; no combinational in->out paths.
// CONFIGURATION
//  PPM_ACC_SPLIT_CPA_EN:
//  - Defined: RESOLVE takes 2 cycles.
//    - Cycle 1 adds the low OUT_DATA_WIDTH/2 bits and registers the carry-out.
//    - Cycle 2 adds the high half plus the registered carry.
//    - Latency becomes N_ACC+2.
//  - Undefined: single-cycle full-width CPA; latency N_ACC+1.
// STRUCTURE
//  - Package booth_ppm_pkg:
//    - state enum {IDLE,ACCUM,RESOLVE,DONE}
//    - functions booth_num(w), ppm_row_w(w), ceil_div(a,b)
//  - Sub-module csa_3to2 (param WIDTH): s=a^b^c, co=maj(a,b,c); instantiated R times in the ACCUM chain.
//  - Elaboration check: error if ROWS_PER_CYCLE<1 or ROWS_PER_CYCLE>BOOTH_NUM.
// TESTING
//  - Use a bench Booth-2 PPM model driving ppm_flat; golden result is a*b mod 2^64.
//  - a=3, b=5 -> c=64'h0F; out_valid exactly 10 edges after accept (11 with SPLIT_CPA_EN).
//  - a=b=32'hFFFFFFFF -> c=64'hFFFFFFFE00000001; a=0, b=any -> c=0.
//  - out_ready low 5 cycles in DONE -> c/out_valid stable; in_valid pulses ignored; in_ready=1 the cycle after handshake.
//  - rst pulsed at ACCUM cycle 4 -> out_valid never rises; next accept with a=7, b=9 -> c=63.
//  - Sweep ROWS_PER_CYCLE in {1,2,5,17} with 10k random pairs: all match, latency N_ACC+1 (17+1, 9+1, 4+1, 1+1).

Source files
------------

// File: rtl/booth_ppm_pkg.sv
// Shared FSM state type and width helpers for the Booth-2 partial-product accumulator.
package booth_ppm_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  function automatic int booth_num(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int ppm_row_w(input int w);
    return w + 4;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/booth_ppm_accum_csa.sv
// Bitwise 3:2 compressor (carry-save adder layer); carry output is unshifted.
module csa_3to2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/booth_ppm_accum.sv
// Multi-cycle carry-save reduction of a Booth-2 partial-product matrix into an unsigned product.
// Optional macro PPM_ACC_SPLIT_CPA_EN splits the final carry-propagate add over two cycles.
//
//   state   | meaning
//   IDLE    | in_ready high, waiting for a matrix
//   ACCUM   | folding ROWS_PER_CYCLE rows per cycle into sum/carry
//   RESOLVE | carry-propagate add of sum+carry into c
//   DONE    | c valid, held until the consumer takes it
module booth_ppm_accum
  import booth_ppm_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 64,
  parameter int ROWS_PER_CYCLE = 2
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         in_valid,
  output logic                                                         in_ready,
  input  logic [booth_num(IN_DATA_WIDTH)*ppm_row_w(IN_DATA_WIDTH)-1:0] ppm_flat,
  output logic                                                         out_valid,
  input  logic                                                         out_ready,
  output logic [OUT_DATA_WIDTH-1:0]                                    c,
  output logic                                                         busy
);

  localparam int BOOTH_NUM = booth_num(IN_DATA_WIDTH);
  localparam int PPM_ROW_W = ppm_row_w(IN_DATA_WIDTH);
  localparam int PPM_W     = BOOTH_NUM * PPM_ROW_W;
  localparam int R         = ROWS_PER_CYCLE;
  localparam int N_ACC     = ceil_div(BOOTH_NUM, R);
  localparam int IDX_W     = $clog2(N_ACC * R + 1);
  localparam int ROWS_PAD  = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((N_ACC - 1) * R);

  if (ROWS_PER_CYCLE < 1 || ROWS_PER_CYCLE > BOOTH_NUM) begin : g_bad_rpc
    $error("booth_ppm_accum: ROWS_PER_CYCLE must lie in 1..BOOTH_NUM");
  end

  state_t                    r_state;
  logic [PPM_W-1:0]          r_ppm;
  logic [OUT_DATA_WIDTH-1:0] r_sum;
  logic [OUT_DATA_WIDTH-1:0] r_carry;
  logic [IDX_W-1:0]          r_row_idx;
  logic [OUT_DATA_WIDTH-1:0] r_c;
  logic                      r_out_valid;
`ifdef PPM_ACC_SPLIT_CPA_EN
  localparam int LO_W = OUT_DATA_WIDTH / 2;
  localparam int HI_W = OUT_DATA_WIDTH - LO_W;
  logic                      r_half;
  logic                      r_cpa_cy;
`endif

  // Row table padded to a power of two so out-of-range indices read as zero rows.
  logic [PPM_ROW_W-1:0] w_rows [ROWS_PAD];
  for (genvar i = 0; i < ROWS_PAD; i++) begin : g_rows
    if (i < BOOTH_NUM) begin : g_real
      assign w_rows[i] = r_ppm[i*PPM_ROW_W +: PPM_ROW_W];
    end else begin : g_zero
      assign w_rows[i] = '0;
    end
  end

  logic [R:0][OUT_DATA_WIDTH-1:0] w_s;
  logic [R:0][OUT_DATA_WIDTH-1:0] w_cy;
  assign w_s[0]  = r_sum;
  assign w_cy[0] = r_carry;

  for (genvar k = 0; k < R; k++) begin : g_chain
    logic [IDX_W-1:0]          w_idx;
    logic [OUT_DATA_WIDTH-1:0] w_row;
    logic [OUT_DATA_WIDTH-1:0] w_co;
    assign w_idx = r_row_idx + IDX_W'(k);
    assign w_row = OUT_DATA_WIDTH'(w_rows[w_idx]) << {w_idx, 1'b0};
    csa_3to2 #(.WIDTH(OUT_DATA_WIDTH)) u_csa (
      .i_a (w_s[k]),
      .i_b (w_cy[k]),
      .i_c (w_row),
      .o_s (w_s[k+1]),
      .o_co(w_co)
    );
    assign w_cy[k+1] = w_co << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ppm       <= '0;
      r_sum       <= '0;
      r_carry     <= '0;
      r_row_idx   <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
`ifdef PPM_ACC_SPLIT_CPA_EN
      r_half      <= 1'b0;
      r_cpa_cy    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_ppm     <= ppm_flat;
            r_sum     <= '0;
            r_carry   <= '0;
            r_row_idx <= '0;
            r_state   <= ACCUM;
          end
        end
        ACCUM: begin
          r_sum     <= w_s[R];
          r_carry   <= w_cy[R];
          r_row_idx <= r_row_idx + IDX_W'(R);
          if (r_row_idx == LAST_IDX) r_state <= RESOLVE;
        end
        RESOLVE: begin
`ifdef PPM_ACC_SPLIT_CPA_EN
          if (!r_half) begin
            {r_cpa_cy, r_c[LO_W-1:0]} <= {1'b0, r_sum[LO_W-1:0]} + {1'b0, r_carry[LO_W-1:0]};
            r_half <= 1'b1;
          end else begin
            r_c[OUT_DATA_WIDTH-1:LO_W] <= r_sum[OUT_DATA_WIDTH-1:LO_W]
                                        + r_carry[OUT_DATA_WIDTH-1:LO_W] + HI_W'(r_cpa_cy);
            r_half      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
`else
          r_c         <= r_sum + r_carry;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
`endif
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign c         = r_c;

endmodule
